// File: rtl/pong_pkg.sv
// Shared pong definitions: paddle timer state encoding and default pulse limits.
package pong_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StTiming = 2'd1,
        StHold   = 2'd2
    } timer_state_e;

    localparam int unsigned TimerWidth    = 9;
    localparam int unsigned TimerMinTicks = 16;
    localparam int unsigned TimerMaxTicks = 480;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector; the delay register samples every clock.
module edge_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sig,
    output logic o_Rise
);

    logic sig_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= i_Sig;
        end
    end

    assign o_Rise = i_Sig & ~sig_q;

endmodule

// File: rtl/timer_555.sv
// Monostable 555-style pulse timer counting timebase ticks; non-retriggerable,
// holds high while the trigger stays asserted past expiry.
module timer_555
    import pong_pkg::*;
#(
    parameter int unsigned p_WIDTH     = TimerWidth,
    parameter int unsigned p_MIN_TICKS = TimerMinTicks,
    parameter int unsigned p_MAX_TICKS = TimerMaxTicks
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Trigger,
    input  logic               i_Tick,
    input  logic [p_WIDTH-1:0] i_Duration,
    input  logic               i_Discharge,
    output logic               o_Output,
    output logic               o_Done,
    output logic [p_WIDTH-1:0] o_Count
);

    localparam logic [p_WIDTH-1:0] MinTicks = p_WIDTH'(p_MIN_TICKS);
    localparam logic [p_WIDTH-1:0] MaxTicks = p_WIDTH'(p_MAX_TICKS);
    localparam logic [p_WIDTH-1:0] OneTick  = p_WIDTH'(1);

    logic               trig_rise;
    logic [p_WIDTH-1:0] dur_clamped;
    timer_state_e       state_q;
    logic [p_WIDTH-1:0] count_q;
    logic               out_q;
    logic               done_q;

    edge_detect u_edge_detect (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Sig   (i_Trigger),
        .o_Rise  (trig_rise)
    );

    always_comb begin
        dur_clamped = i_Duration;
        if (i_Duration < MinTicks) begin
            dur_clamped = MinTicks;
        end else if (i_Duration > MaxTicks) begin
            dur_clamped = MaxTicks;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= StIdle;
            count_q <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_Discharge) begin
                state_q <= StIdle;
                count_q <= '0;
                out_q   <= 1'b0;
                done_q  <= (state_q != StIdle);
            end else begin
                case (state_q)
                    StIdle: begin
                        // A tick on the loading clock is deliberately not counted.
                        if (trig_rise) begin
                            count_q <= dur_clamped;
                            state_q <= StTiming;
                            out_q   <= 1'b1;
                        end
                    end
                    StTiming: begin
                        if (i_Tick) begin
                            if (count_q == OneTick) begin
                                count_q <= '0;
                                if (i_Trigger) begin
                                    state_q <= StHold;
                                end else begin
                                    state_q <= StIdle;
                                    out_q   <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                count_q <= count_q - OneTick;
                            end
                        end
                    end
                    StHold: begin
                        if (!i_Trigger) begin
                            state_q <= StIdle;
                            out_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        count_q <= '0;
                        out_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_Output = out_q;
    assign o_Done   = done_q;
    assign o_Count  = count_q;

endmodule
